lbp_engine_param: RTL

- Parametrised local-binary-pattern engine. Scans a gray image of 2^W_LOG2 x 2^H_LOG2 pixels in raster order from a 1-cycle-latency gray memory.
- Writes one 8-bit LBP code per pixel address to the result memory.
- Reuses the 3x3 window across a row: 9 reads for the first interior pixel, 3 reads per subsequent pixel.
- Adds output back-pressure, configurable pixel width and selectable border handling.

---
 rtl/lbp_engine_param.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lbp_engine_param.sv
// Local-binary-pattern engine: raster scan of a 2^W_LOG2 x 2^H_LOG2 gray image, one code per pixel.
// Optional macro LBP_UNIFORM_EN selects the rotation-invariant uniform code instead of the raw code.
module lbp_engine_param #(
  parameter int unsigned W_LOG2       = 7,
  parameter int unsigned H_LOG2       = 7,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BORDER_WRITE = 1,
  localparam int unsigned ADDR_W      = W_LOG2 + H_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  output logic              lbp_valid,
  input  logic              lbp_ready,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  typedef enum logic [2:0] {
    StIdle, StScan, StFill, StSlide, StCalc, StWrite, StDone
  } state_e;

  state_e            state_q;
  logic [H_LOG2-1:0] row_q;
  logic [W_LOG2-1:0] col_q;
  logic [3:0]        idx_q;
  logic [3:0]        cap_idx_q;
  logic              cap_vld_q;
  logic [DATA_W-1:0] win_q   [9];
  logic [DATA_W-1:0] win_cur [9];
  logic [7:0]        raw_code;
  logic [7:0]        code;
  logic              is_border;
  logic              is_last;
  logic [3:0]        idx_next;

  assign is_border = (row_q == '0) || (row_q == '1) || (col_q == '0) || (col_q == '1);
  assign is_last   = (row_q == '1) && (col_q == '1);
  // FILL walks g0..g8 one by one; SLIDE only fetches the right column (g2, g5, g8).
  assign idx_next  = idx_q + ((state_q == StFill) ? 4'd1 : 4'd3);

  // Address of window element idx (row-major 3x3) around centre (r, c).
  function automatic logic [ADDR_W-1:0] win_addr(input logic [H_LOG2-1:0] r,
                                                 input logic [W_LOG2-1:0] c,
                                                 input logic [3:0]        idx);
    logic [1:0]        dr;
    logic [1:0]        dc;
    logic [H_LOG2-1:0] ar;
    logic [W_LOG2-1:0] ac;
    case (idx)
      4'd0, 4'd1, 4'd2: dr = 2'd0;
      4'd3, 4'd4, 4'd5: dr = 2'd1;
      default:          dr = 2'd2;
    endcase
    case (idx)
      4'd0, 4'd3, 4'd6: dc = 2'd0;
      4'd1, 4'd4, 4'd7: dc = 2'd1;
      default:          dc = 2'd2;
    endcase
    ar = r + H_LOG2'(dr) - H_LOG2'(1);
    ac = c + W_LOG2'(dc) - W_LOG2'(1);
    return {ar, ac};
  endfunction

  // Window as seen this cycle, including the read returning now.
  always_comb begin
    win_cur = win_q;
    if (cap_vld_q) win_cur[cap_idx_q] = gray_data;
    raw_code[0] = win_cur[0] >= win_cur[4];
    raw_code[1] = win_cur[1] >= win_cur[4];
    raw_code[2] = win_cur[2] >= win_cur[4];
    raw_code[3] = win_cur[3] >= win_cur[4];
    raw_code[4] = win_cur[5] >= win_cur[4];
    raw_code[5] = win_cur[6] >= win_cur[4];
    raw_code[6] = win_cur[7] >= win_cur[4];
    raw_code[7] = win_cur[8] >= win_cur[4];
  end

`ifdef LBP_UNIFORM_EN
  logic [7:0] ring;
  logic [7:0] trans;
  logic [3:0] n_ones;
  logic [3:0] n_trans;

  // Ring order g0,g1,g2,g5,g8,g7,g6,g3 mapped onto raw code bits.
  always_comb begin
    ring    = {raw_code[3], raw_code[5], raw_code[6], raw_code[7],
               raw_code[4], raw_code[2], raw_code[1], raw_code[0]};
    trans   = ring ^ {ring[0], ring[7:1]};
    n_ones  = '0;
    n_trans = '0;
    for (int i = 0; i < 8; i++) begin
      n_ones  = n_ones + {3'b000, ring[i]};
      n_trans = n_trans + {3'b000, trans[i]};
    end
    code = (n_trans <= 4'd2) ? {4'b0000, n_ones} : 8'd9;
  end
`else
  assign code = raw_code;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      cap_idx_q <= '0;
      cap_vld_q <= 1'b0;
      win_q     <= '{default: '0};
      gray_req  <= 1'b0;
      gray_addr <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
    end else begin
      cap_vld_q <= gray_req;
      cap_idx_q <= idx_q;
      win_q     <= win_cur;
      case (state_q)
        StIdle: begin
          if (gray_ready) state_q <= StScan;
        end
        StScan: begin
          if (is_border) begin
            if (BORDER_WRITE != 0) begin
              lbp_valid <= 1'b1;
              lbp_addr  <= {row_q, col_q};
              lbp_data  <= '0;
              state_q   <= StWrite;
            end else if (is_last) begin
              finish  <= 1'b1;
              state_q <= StDone;
            end else begin
              {row_q, col_q} <= {row_q, col_q} + ADDR_W'(1);
            end
          end else if (col_q == W_LOG2'(1)) begin
            idx_q     <= 4'd0;
            gray_req  <= 1'b1;
            gray_addr <= win_addr(row_q, col_q, 4'd0);
            state_q   <= StFill;
          end else begin
            win_q[0]  <= win_q[1];
            win_q[1]  <= win_q[2];
            win_q[3]  <= win_q[4];
            win_q[4]  <= win_q[5];
            win_q[6]  <= win_q[7];
            win_q[7]  <= win_q[8];
            idx_q     <= 4'd2;
            gray_req  <= 1'b1;
            gray_addr <= win_addr(row_q, col_q, 4'd2);
            state_q   <= StSlide;
          end
        end
        StFill, StSlide: begin
          if (idx_q == 4'd8) begin
            gray_req <= 1'b0;
            state_q  <= StCalc;
          end else begin
            idx_q     <= idx_next;
            gray_addr <= win_addr(row_q, col_q, idx_next);
          end
        end
        StCalc: begin
          lbp_valid <= 1'b1;
          lbp_addr  <= {row_q, col_q};
          lbp_data  <= code;
          state_q   <= StWrite;
        end
        StWrite: begin
          if (lbp_ready) begin
            lbp_valid <= 1'b0;
            if (is_last) begin
              finish  <= 1'b1;
              state_q <= StDone;
            end else begin
              {row_q, col_q} <= {row_q, col_q} + ADDR_W'(1);
              state_q        <= StScan;
            end
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
